load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/risc_v_32i_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_32i_pkg.sv
// Shared RV32I definitions for the load/store path: register width,
// memory funct3 size/sign codes, LSU state encoding and access checking.
package risc_v_32i;

    localparam int REG_SIZE = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_t;

    // True when an access must be rejected without touching memory:
    // an unsupported funct3 for the direction, or an address that is not
    // naturally aligned for the access size.
    function automatic logic lsu_access_error(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = (funct3 >= 3'b011);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        misaligned = ((funct3[1:0] == F3_H[1:0]) && addr_lo[0]) ||
                     ((funct3[1:0] == F3_W[1:0]) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic for the LSU: byte enables and data
// replication for stores, lane selection and sign/zero extension for loads.
module lsu_align
    import risc_v_32i::*;
(
    input  logic [1:0]          st_size,
    input  logic [1:0]          st_addr_lo,
    input  logic [REG_SIZE-1:0] st_data,
    output logic [3:0]          st_be,
    output logic [REG_SIZE-1:0] st_wdata,
    input  logic [2:0]          ld_funct3,
    input  logic [1:0]          ld_addr_lo,
    input  logic [REG_SIZE-1:0] ld_word,
    output logic [REG_SIZE-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: enables follow the size and low address bits, and the data
    // is replicated so the selected lanes carry it whatever the offset.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = st_data;
        case (st_size)
            F3_B[1:0]: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H[1:0]: begin
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            F3_W[1:0]: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_be    = 4'b0000;
                st_wdata = st_data;
            end
        endcase
    end

    // Load side: pick the addressed lane of the returned word, then extend
    // it to full register width according to the signedness in funct3.
    always_comb begin
        ld_byte = ld_word[7:0];
        case (ld_addr_lo)
            2'b00:   ld_byte = ld_word[7:0];
            2'b01:   ld_byte = ld_word[15:8];
            2'b10:   ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{(REG_SIZE-8){ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {{(REG_SIZE-8){1'b0}}, ld_byte};
            F3_H:    ld_data = {{(REG_SIZE-16){ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {{(REG_SIZE-16){1'b0}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one access at a time from execute, issues a
// word-aligned request on a gnt/rvalid memory port and returns a one-cycle
// completion pulse with writeback data or an error flag.
module load_store_unit
    import risc_v_32i::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [REG_SIZE-1:0] req_addr,
    input  logic [REG_SIZE-1:0] req_wdata,
    input  logic [4:0]          req_rd,
    output logic                mem_req,
    output logic                mem_we,
    output logic [REG_SIZE-1:0] mem_addr,
    output logic [3:0]          mem_be,
    output logic [REG_SIZE-1:0] mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [REG_SIZE-1:0] mem_rdata,
    output logic                rsp_valid,
    output logic [4:0]          rsp_rd,
    output logic [REG_SIZE-1:0] rsp_data,
    output logic                rsp_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    lsu_state_t          state;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [1:0]          r_addr_lo;
    logic [4:0]          r_rd;
    logic [TW-1:0]       timer;

    logic [3:0]          align_be;
    logic [REG_SIZE-1:0] align_wdata;
    logic [REG_SIZE-1:0] align_load;

    // Store lanes come straight from the incoming request so they can be
    // registered onto the memory port at accept; load extraction uses the
    // request fields captured at accept together with the returned word.
    lsu_align u_align (
        .st_size    (req_funct3[1:0]),
        .st_addr_lo (req_addr[1:0]),
        .st_data    (req_wdata),
        .st_be      (align_be),
        .st_wdata   (align_wdata),
        .ld_funct3  (r_funct3),
        .ld_addr_lo (r_addr_lo),
        .ld_word    (mem_rdata),
        .ld_data    (align_load)
    );

    // Access sequencer: all outputs are registered; the shared REQ+WAIT timer
    // bounds how long a stalled memory can hold the unit before it errors out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LSU_IDLE;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= 5'd0;
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
            r_rd      <= 5'd0;
            timer     <= '0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        r_rd      <= req_rd;
                        timer     <= '0;
                        if (lsu_access_error(req_we, req_funct3, req_addr[1:0])) begin
                            state     <= LSU_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_rd    <= req_rd;
                        end else begin
                            state     <= LSU_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[REG_SIZE-1:2], 2'b00};
                            mem_be    <= align_be;
                            mem_wdata <= align_wdata;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        timer   <= timer + 1'b1;
                        if (r_we) begin
                            state     <= LSU_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= '0;
                            rsp_rd    <= r_rd;
                        end else begin
                            state <= LSU_WAIT;
                        end
                    end else if (timer >= TIMER_LAST) begin
                        mem_req   <= 1'b0;
                        state     <= LSU_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_rd    <= r_rd;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LSU_WAIT: begin
                    if (mem_rvalid) begin
                        state     <= LSU_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= align_load;
                        rsp_rd    <= r_rd;
                    end else if (timer >= TIMER_LAST) begin
                        state     <= LSU_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_rd    <= r_rd;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LSU_RESP: begin
                    state     <= LSU_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= LSU_IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte/half/word loads and stores,
// alignment and funct3 errors, stalled grant, timeout and mid-access reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int vectors = 0;
    int miscompares = 0;
    int rsp_count = 0;
    bit mem_seen = 1'b0;
    int waited;
    int snap;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rd     (rsp_rd),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Record completion pulses and any memory request activity, sampled mid-cycle.
    always @(negedge clk) begin
        if (rsp_valid) rsp_count++;
        if (mem_req) mem_seen = 1'b1;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one request for a single cycle; returns at the negedge after acceptance.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd);
        checkOutput("req_ready", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    // Act as memory: withhold gnt for gnt_delay cycles (checking the request is
    // held), grant, then optionally return read data the following cycle.
    task automatic serveMem(input int gnt_delay, input bit is_load, input bit give_rvalid,
                            input logic [31:0] rdata, input bit stray_rvalid);
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  b;
        checkOutput("mem_req_up", {31'd0, mem_req}, 32'd1);
        a = mem_addr;
        b = mem_be;
        w = mem_wdata;
        for (int i = 0; i < gnt_delay; i++) begin
            if (stray_rvalid && i == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0BAD0;
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            checkOutput("hold_req", {31'd0, mem_req}, 32'd1);
            checkOutput("hold_addr", mem_addr, a);
            checkOutput("hold_be", {28'd0, mem_be}, {28'd0, b});
            checkOutput("hold_wdata", mem_wdata, w);
            checkOutput("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        if (is_load && give_rvalid) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
    endtask

    // Bounded wait for rsp_valid; reports how many extra cycles it took.
    task automatic waitResponse(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) checkOutput("rsp_wait", {31'd0, rsp_valid}, 32'd1);
    endtask

    // The completion pulse must drop after one cycle and the unit be ready again.
    task automatic finishResponse();
        @(negedge clk);
        checkOutput("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        checkOutput("ready_again", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        $display("[TB] load_store_unit directed test start");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_mem_be", {28'd0, mem_be}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);

        // SB at 0x103
        applyStimulus(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd0);
        checkOutput("sb_addr", mem_addr, 32'h0000_0100);
        checkOutput("sb_be", {28'd0, mem_be}, 32'h8);
        checkOutput("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        checkOutput("sb_we", {31'd0, mem_we}, 32'd1);
        serveMem(0, 1'b0, 1'b0, 32'd0, 1'b0);
        waitResponse(waited);
        checkOutput("sb_latency", waited, 0);
        checkOutput("sb_err", {31'd0, rsp_err}, 32'd0);
        checkOutput("sb_data", rsp_data, 32'd0);
        finishResponse();

        // LB at 0x201, minimum latency path
        applyStimulus(1'b0, 3'b000, 32'h0000_0201, 32'd0, 5'd5);
        checkOutput("lb_addr", mem_addr, 32'h0000_0200);
        checkOutput("lb_be", {28'd0, mem_be}, 32'h2);
        checkOutput("lb_we", {31'd0, mem_we}, 32'd0);
        serveMem(0, 1'b1, 1'b1, 32'h0000_8000, 1'b0);
        waitResponse(waited);
        checkOutput("lb_latency", waited, 0);
        checkOutput("lb_data", rsp_data, 32'hFFFF_FF80);
        checkOutput("lb_rd", {27'd0, rsp_rd}, 32'd5);
        checkOutput("lb_err", {31'd0, rsp_err}, 32'd0);
        finishResponse();

        // LBU at 0x201
        applyStimulus(1'b0, 3'b100, 32'h0000_0201, 32'd0, 5'd6);
        serveMem(0, 1'b1, 1'b1, 32'h0000_8000, 1'b0);
        waitResponse(waited);
        checkOutput("lbu_data", rsp_data, 32'h0000_0080);
        checkOutput("lbu_rd", {27'd0, rsp_rd}, 32'd6);
        finishResponse();

        // LH at 0x202
        applyStimulus(1'b0, 3'b001, 32'h0000_0202, 32'd0, 5'd7);
        checkOutput("lh_be", {28'd0, mem_be}, 32'hC);
        serveMem(0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        waitResponse(waited);
        checkOutput("lh_data", rsp_data, 32'h0000_1234);
        finishResponse();

        // LW at 0x202: misaligned, no memory access
        mem_seen = 1'b0;
        applyStimulus(1'b0, 3'b010, 32'h0000_0202, 32'd0, 5'd8);
        waitResponse(waited);
        checkOutput("lwmis_latency", waited, 0);
        checkOutput("lwmis_err", {31'd0, rsp_err}, 32'd1);
        checkOutput("lwmis_data", rsp_data, 32'd0);
        finishResponse();
        checkOutput("lwmis_nomem", {31'd0, mem_seen}, 32'd0);

        // Store funct3 011 is illegal
        mem_seen = 1'b0;
        applyStimulus(1'b1, 3'b011, 32'h0000_0400, 32'h5555_5555, 5'd0);
        waitResponse(waited);
        checkOutput("sill_err", {31'd0, rsp_err}, 32'd1);
        finishResponse();
        checkOutput("sill_nomem", {31'd0, mem_seen}, 32'd0);

        // SH at 0x106
        applyStimulus(1'b1, 3'b001, 32'h0000_0106, 32'h1234_CAFE, 5'd0);
        checkOutput("sh_be", {28'd0, mem_be}, 32'hC);
        checkOutput("sh_wdata", mem_wdata, 32'hCAFE_CAFE);
        checkOutput("sh_addr", mem_addr, 32'h0000_0104);
        serveMem(0, 1'b0, 1'b0, 32'd0, 1'b0);
        waitResponse(waited);
        checkOutput("sh_err", {31'd0, rsp_err}, 32'd0);
        finishResponse();

        // LW with gnt withheld 3 cycles and a stray rvalid while in REQ
        applyStimulus(1'b0, 3'b010, 32'h0000_0300, 32'd0, 5'd9);
        checkOutput("lws_be", {28'd0, mem_be}, 32'hF);
        serveMem(3, 1'b1, 1'b1, 32'h1122_3344, 1'b1);
        waitResponse(waited);
        checkOutput("lws_data", rsp_data, 32'h1122_3344);
        checkOutput("lws_rd", {27'd0, rsp_rd}, 32'd9);
        checkOutput("lws_err", {31'd0, rsp_err}, 32'd0);
        finishResponse();

        // LW with no rvalid: times out after 8 cycles in REQ+WAIT
        applyStimulus(1'b0, 3'b010, 32'h0000_0310, 32'd0, 5'd10);
        serveMem(0, 1'b1, 1'b0, 32'd0, 1'b0);
        waitResponse(waited);
        checkOutput("to_cycles", waited, 7);
        checkOutput("to_err", {31'd0, rsp_err}, 32'd1);
        checkOutput("to_data", rsp_data, 32'd0);
        checkOutput("to_mem_req", {31'd0, mem_req}, 32'd0);
        finishResponse();

        // Reset while in WAIT aborts the access silently
        applyStimulus(1'b0, 3'b010, 32'h0000_0320, 32'd0, 5'd11);
        serveMem(0, 1'b1, 1'b0, 32'd0, 1'b0);
        snap = rsp_count;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("abort_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("abort_rsp", {31'd0, rsp_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFACE_FACE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_rsp", rsp_count - snap, 0);

        // Next request after the abort completes normally
        applyStimulus(1'b0, 3'b010, 32'h0000_0330, 32'd0, 5'd12);
        serveMem(0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        waitResponse(waited);
        checkOutput("post_data", rsp_data, 32'hDEAD_BEEF);
        checkOutput("post_rd", {27'd0, rsp_rd}, 32'd12);
        checkOutput("post_err", {31'd0, rsp_err}, 32'd0);
        finishResponse();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
